datapath_seq: RTL and testbench
===============================

Name: datapath_seq

Overview:
- Parametrised successor to the 16-bit, 8-register datapath.
- Contains a register file, A/B operand registers, a shifter on B, a 4-op ALU, a C result register and status flags N/Z/V.
- An internal sequencer replaces the hand-driven en_A/en_B/en_C/w_en strobes: one start/ready handshake runs a full read-execute-writeback instruction.
- Sits between the instruction decoder and the register file/memory interface of the CPU.

Parameters:
- DATA_W, 16: datapath width in bits; must be ≥ 4.
- NREGS, 8: number of general registers; must be a power of 2, ≥ 2.
- ADDR_W, $clog2(NREGS): register address width (derived; not to be overridden).
- IMM_W, 5: immediate field width; sign-extended to DATA_W.

Ports:
- clk  in  1  Rising-edge clock.
- rst_n  in  1  Synchronous active-low reset.
- start  in  1  Instruction request; accepted when start && ready.
- ready  out  1  High in IDLE only.
- op_load  in  1  1 = write datapath_in to rd (load); 0 = ALU instruction.
- rd  in  ADDR_W  Destination register.
- rn  in  ADDR_W  Source A register.
- rm  in  ADDR_W  Source B register.
- shift_op  in  2  00 none, 01 LSL1, 10 LSR1, 11 ASR1, applied to B.
- alu_op  in  2  00 ADD, 01 SUB (A−B), 10 AND, 11 NOT B.
- sel_A  in  1  1 = ALU A operand forced to 0.
- sel_B  in  1  1 = ALU B operand is sign-extended imm, bypassing the shifter.
- imm  in  IMM_W  Immediate value.
- wb_en  in  1  1 = write the ALU result to rd; 0 = compare-only (flags and C still update).
- datapath_in  in  DATA_W  Load data.
- datapath_out  out  DATA_W  C register.
- Z_out  out  1  Zero flag.
- N_out  out  1  Negative flag (result MSB).
- V_out  out  1  Signed overflow flag (ADD/SUB only; 0 for AND/NOT).
- done  out  1  One-cycle pulse when the instruction retires.

Behaviour:
- Reset (rst_n=0 at a clock edge, overriding everything):
  - State goes to IDLE; all registers, A, B, C and flags go to 0.
  - ready=1 and done=0 from the next cycle.
- Instruction capture: all instruction fields are captured on the accepting edge. Inputs are don't-care while busy, except datapath_in, which is also sampled only at acceptance.
- FSM states: IDLE, RD_A, RD_B, EXEC, WB.
  - IDLE: start with op_load=1 → WB (load path); start with op_load=0 → RD_A; otherwise stay in IDLE.
  - RD_A: A ← R[rn] → RD_B.
  - RD_B: B ← R[rm] → EXEC.
  - EXEC: C ← ALU result; N/Z/V ← flags of that result → WB.
  - WB: if load, R[rd] ← captured datapath_in; if ALU and wb_en, R[rd] ← C. Then done=1 for that cycle → IDLE.
- Latency:
  - ALU instruction: start edge to done is 4 cycles.
  - Load: 1 cycle.
  - ready returns on the cycle after done, so back-to-back issue spacing is 5 cycles (ALU) or 2 cycles (load).
- Hazards:
  - Reads occur in RD_A/RD_B, after the previous WB has committed, so no forwarding is needed.
  - rn == rm == rd is legal.
- Arithmetic: modulo 2^DATA_W.
  - V for ADD = (A[msb] == B[msb]) && (R[msb] != A[msb]).
  - V for SUB = (A[msb] != B[msb]) && (R[msb] != A[msb]).
- Shifter:
  - LSL1: shift in 0 at bit 0.
  - LSR1: shift in 0 at the MSB.
  - ASR1: replicate the MSB.
- Flags and C are unchanged by load instructions.
- Reset mid-instruction aborts it: no writeback and no done pulse.
- start while not ready is ignored (not queued).

Test Plan:
- Load then ADD: load R0=9, load R1=8; ADD rd=2, rn=0, rm=1 → done 4 cycles after start; datapath_out=17, R2=17, Z=0, N=0, V=0.
- sel_A=1, alu_op=ADD, rm=R1(8), shift_op=00 → datapath_out=8. Repeat with sel_A=0, sel_B=1, imm=5'b11111 → 9+(−1)=8.
- Shift × ALU sweep with A=9, B=8:
  - shift 01 (B=16): ADD=25, SUB=0xFFF9, AND=0, NOT=0xFFEF.
  - shift 10 (B=4): ADD=13, SUB=5, AND=0, NOT=0xFFFB.
  - shift 11 (B=4): same results as shift 10.
- Flags:
  - 0x7FFF + 1 → 0x8000, V=1, N=1.
  - SUB 9 − 9 with wb_en=0 → Z=1, rd unchanged.
  - AND result with MSB set → V=0.
- Handshake: hold start high continuously → ready low for 4 cycles after acceptance, exactly one done per instruction, a second instruction accepted only when ready=1. start while busy has no effect.
- Reset mid-EXEC with rd=3 preloaded to 0x00AA → no done; all registers, including R3, and flags read 0 after reset; ready=1 on the next cycle. Rerun with DATA_W=8, NREGS=4: 0x7F+1 → V=1.

Source files
------------

// File: rtl/datapath_seq.sv
// datapath_seq
//   Sequenced datapath: register file, A/B operand registers, a one-bit
//   shifter on B, a four-operation ALU, the C result register and the N/Z/V
//   status flags. One start/ready handshake runs a whole instruction:
//   read A, read B, execute, write back. A load instruction skips straight
//   to write back.
//
// Ports
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   start / ready       instruction request; taken when start && ready
//   op_load             1 = load datapath_in into rd, 0 = ALU instruction
//   rd, rn, rm          destination, source A and source B register numbers
//   shift_op            00 none, 01 LSL1, 10 LSR1, 11 ASR1 (applied to B)
//   alu_op              00 ADD, 01 SUB (A-B), 10 AND, 11 NOT B
//   sel_A, sel_B        force A operand to 0 / use sign-extended imm as B
//   imm                 immediate field
//   wb_en               write the ALU result to rd (0 = compare only)
//   datapath_in         load data, sampled when the instruction is accepted
//   datapath_out        C register
//   Z_out, N_out, V_out status flags of the last ALU instruction
//   done                one-cycle pulse as the instruction retires
module datapath_seq #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = $clog2(NREGS),
  parameter int IMM_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ready,
  input  logic              op_load,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rn,
  input  logic [ADDR_W-1:0] rm,
  input  logic [1:0]        shift_op,
  input  logic [1:0]        alu_op,
  input  logic              sel_A,
  input  logic              sel_B,
  input  logic [IMM_W-1:0]  imm,
  input  logic              wb_en,
  input  logic [DATA_W-1:0] datapath_in,
  output logic [DATA_W-1:0] datapath_out,
  output logic              Z_out,
  output logic              N_out,
  output logic              V_out,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_c;
  logic              r_n;
  logic              r_z;
  logic              r_v;

  // Instruction fields held for the whole instruction, so the decoder is
  // free to move on as soon as the request is accepted.
  logic              r_opLoad;
  logic [ADDR_W-1:0] r_rd;
  logic [ADDR_W-1:0] r_rn;
  logic [ADDR_W-1:0] r_rm;
  logic [1:0]        r_shiftOp;
  logic [1:0]        r_aluOp;
  logic              r_selA;
  logic              r_selB;
  logic [IMM_W-1:0]  r_imm;
  logic              r_wbEn;
  logic [DATA_W-1:0] r_loadData;

  logic [DATA_W-1:0] w_immExt;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_opA;
  logic [DATA_W-1:0] w_opB;
  logic [DATA_W-1:0] w_result;
  logic              w_ovf;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic; loads go straight to write back since they need
  // neither operand nor the ALU.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = op_load ? WB : RD_A;
      RD_A:    w_nextState = RD_B;
      RD_B:    w_nextState = EXEC;
      EXEC:    w_nextState = WB;
      WB:      w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  assign ready = (r_state == IDLE);
  assign done  = (r_state == WB);

  // Size cast of a signed value sign-extends the immediate to DATA_W.
  assign w_immExt = DATA_W'($signed(r_imm));

  // Shifter on B, then operand selection and the ALU. Overflow only has
  // meaning for ADD/SUB; the logical ops report V = 0.
  always_comb begin
    w_shifted = r_b;
    case (r_shiftOp)
      2'b01:   w_shifted = {r_b[DATA_W-2:0], 1'b0};
      2'b10:   w_shifted = {1'b0, r_b[DATA_W-1:1]};
      2'b11:   w_shifted = {r_b[DATA_W-1], r_b[DATA_W-1:1]};
      default: w_shifted = r_b;
    endcase

    w_opA = r_selA ? '0 : r_a;
    w_opB = r_selB ? w_immExt : w_shifted;

    w_result = '0;
    w_ovf    = 1'b0;
    case (r_aluOp)
      2'b00: begin
        w_result = w_opA + w_opB;
        w_ovf    = (w_opA[DATA_W-1] == w_opB[DATA_W-1]) &&
                   (w_result[DATA_W-1] != w_opA[DATA_W-1]);
      end
      2'b01: begin
        w_result = w_opA - w_opB;
        w_ovf    = (w_opA[DATA_W-1] != w_opB[DATA_W-1]) &&
                   (w_result[DATA_W-1] != w_opA[DATA_W-1]);
      end
      2'b10:   w_result = w_opA & w_opB;
      default: w_result = ~w_opB;
    endcase
  end

  // Datapath registers. Each stage touches only its own registers, and the
  // register file is written on the edge leaving WB, before the next
  // instruction can reach RD_A, so no forwarding path is needed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_n        <= 1'b0;
      r_z        <= 1'b0;
      r_v        <= 1'b0;
      r_opLoad   <= 1'b0;
      r_rd       <= '0;
      r_rn       <= '0;
      r_rm       <= '0;
      r_shiftOp  <= '0;
      r_aluOp    <= '0;
      r_selA     <= 1'b0;
      r_selB     <= 1'b0;
      r_imm      <= '0;
      r_wbEn     <= 1'b0;
      r_loadData <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_opLoad   <= op_load;
            r_rd       <= rd;
            r_rn       <= rn;
            r_rm       <= rm;
            r_shiftOp  <= shift_op;
            r_aluOp    <= alu_op;
            r_selA     <= sel_A;
            r_selB     <= sel_B;
            r_imm      <= imm;
            r_wbEn     <= wb_en;
            r_loadData <= datapath_in;
          end
        end
        RD_A: r_a <= r_regs[r_rn];
        RD_B: r_b <= r_regs[r_rm];
        EXEC: begin
          r_c <= w_result;
          r_n <= w_result[DATA_W-1];
          r_z <= (w_result == '0);
          r_v <= w_ovf;
        end
        WB: begin
          if (r_opLoad)    r_regs[r_rd] <= r_loadData;
          else if (r_wbEn) r_regs[r_rd] <= r_c;
        end
        default: ;
      endcase
    end
  end

  assign datapath_out = r_c;
  assign Z_out        = r_z;
  assign N_out        = r_n;
  assign V_out        = r_v;

endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq
//   Directed bench for datapath_seq. A 16-bit/8-register instance carries
//   most of the tests; an 8-bit/4-register instance checks that overflow
//   follows the narrower width. Expected ALU results come from a small
//   behavioural model, queued when an instruction is issued and popped when
//   the DUT pulses done.
module tb_datapath_seq;

  // Clock and reset shared by both instances.
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start;
  logic        opLoad;
  logic [2:0]  rd, rn, rm;
  logic [1:0]  shiftOp, aluOp;
  logic        selA, selB;
  logic [4:0]  imm;
  logic        wbEn;
  logic [15:0] din;
  logic        ready;
  logic [15:0] dout;
  logic        zOut, nOut, vOut;
  logic        done;

  datapath_seq #(.DATA_W(16), .NREGS(8), .IMM_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .op_load(opLoad), .rd(rd), .rn(rn), .rm(rm),
    .shift_op(shiftOp), .alu_op(aluOp), .sel_A(selA), .sel_B(selB),
    .imm(imm), .wb_en(wbEn), .datapath_in(din), .datapath_out(dout),
    .Z_out(zOut), .N_out(nOut), .V_out(vOut), .done(done)
  );

  // Narrow instance: only loads and a plain ADD are issued to it.
  logic       s8Start, s8OpLoad, s8Ready, s8Z, s8N, s8V, s8Done;
  logic [1:0] s8Rd, s8Rn, s8Rm;
  logic [7:0] s8Din, s8Out;
  logic [1:0] s8Zero2;
  logic       s8Zero1, s8WbEn;
  logic [4:0] s8Imm;

  datapath_seq #(.DATA_W(8), .NREGS(4), .IMM_W(5)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8Start), .ready(s8Ready),
    .op_load(s8OpLoad), .rd(s8Rd), .rn(s8Rn), .rm(s8Rm),
    .shift_op(s8Zero2), .alu_op(s8Zero2), .sel_A(s8Zero1), .sel_B(s8Zero1),
    .imm(s8Imm), .wb_en(s8WbEn), .datapath_in(s8Din), .datapath_out(s8Out),
    .Z_out(s8Z), .N_out(s8N), .V_out(s8V), .done(s8Done)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        n;
    logic        z;
    logic        v;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mdlReg [8];
  exp_t        mdlState;
  int          nCompared   = 0;
  int          nMismatched = 0;

  // Behavioural ALU: shifts done arithmetically, overflow judged by whether
  // the true signed result fits in 16 bits.
  function automatic exp_t modelAlu(input logic [15:0] a, input logic [15:0] b,
                                    input logic [1:0] sh, input logic [1:0] al,
                                    input logic sa, input logic sbSel,
                                    input logic [4:0] im);
    exp_t        e;
    logic [15:0] ao, bo, res;
    int          ia, ib, full;
    logic        v;
    ao = sa ? 16'd0 : a;
    case (sh)
      2'd1:    bo = b * 2;
      2'd2:    bo = b / 2;
      2'd3:    bo = (b / 2) | (b & 16'h8000);
      default: bo = b;
    endcase
    if (sbSel) bo = {{11{im[4]}}, im};
    ia = $signed(ao);
    ib = $signed(bo);
    v  = 1'b0;
    case (al)
      2'd0: begin full = ia + ib; res = ao + bo; v = (full > 32767) || (full < -32768); end
      2'd1: begin full = ia - ib; res = ao - bo; v = (full > 32767) || (full < -32768); end
      2'd2: res = ao & bo;
      default: res = ~bo;
    endcase
    e.data = res;
    e.n    = res[15];
    e.z    = (res == 16'd0);
    e.v    = v;
    return e;
  endfunction

  // One comparison: count it, and report tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pop the oldest expectation and compare it with C and the flags.
  task automatic checkScoreboard();
    exp_t e;
    checkOutput("sbDepth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("C", dout, e.data);
      checkOutput("N", nOut, e.n);
      checkOutput("Z", zOut, e.z);
      checkOutput("V", vOut, e.v);
    end
  endtask

  // Issue one instruction, update the model, wait (bounded) for done and
  // check latency, results and the end of the done pulse.
  task automatic applyStimulus(input logic tLoad, input logic [2:0] tRd,
                               input logic [2:0] tRn, input logic [2:0] tRm,
                               input logic [1:0] tShift, input logic [1:0] tAlu,
                               input logic tSelA, input logic tSelB,
                               input logic [4:0] tImm, input logic tWb,
                               input logic [15:0] tData);
    int   waitCnt, lat;
    exp_t e;
    waitCnt = 0;
    while (ready !== 1'b1 && waitCnt < 10) begin
      @(posedge clk); #1; waitCnt++;
    end
    checkOutput("readyBeforeIssue", ready, 1);
    opLoad = tLoad; rd = tRd; rn = tRn; rm = tRm; shiftOp = tShift; aluOp = tAlu;
    selA = tSelA; selB = tSelB; imm = tImm; wbEn = tWb; din = tData;
    start = 1'b1;
    if (tLoad) begin
      e = mdlState;
      mdlReg[tRd] = tData;
    end else begin
      e = modelAlu(mdlReg[tRn], mdlReg[tRm], tShift, tAlu, tSelA, tSelB, tImm);
      mdlState = e;
      if (tWb) mdlReg[tRd] = e.data;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    checkOutput("doneSeen", done, 1);
    checkOutput("latency", lat, tLoad ? 1 : 4);
    checkScoreboard();
    @(posedge clk); #1;
    checkOutput("donePulseEnds", done, 0);
    checkOutput("readyAfterDone", ready, 1);
  endtask

  task automatic loadReg(input logic [2:0] r, input logic [15:0] data);
    applyStimulus(1'b1, r, 3'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, data);
  endtask

  // Read a register back through the ALU as 0 + R[r] without writeback.
  task automatic readRegExpect(input logic [2:0] r, input logic [15:0] lit);
    applyStimulus(1'b0, 3'd0, 3'd0, r, 2'd0, 2'd0, 1'b1, 1'b0, 5'd0, 1'b0, 16'd0);
    checkOutput($sformatf("R%0d", r), dout, lit);
  endtask

  // Issue one instruction to the narrow instance and wait (bounded) for done.
  task automatic applyStimulus8(input logic tLoad, input logic [1:0] tRd,
                                input logic [1:0] tRn, input logic [1:0] tRm,
                                input logic [7:0] tData);
    int cnt;
    cnt = 0;
    while (s8Ready !== 1'b1 && cnt < 10) begin
      @(posedge clk); #1; cnt++;
    end
    s8OpLoad = tLoad; s8Rd = tRd; s8Rn = tRn; s8Rm = tRm; s8Din = tData;
    s8Start = 1'b1;
    @(posedge clk); #1;
    s8Start = 1'b0;
    cnt = 1;
    while (s8Done !== 1'b1 && cnt < 10) begin
      @(posedge clk); #1; cnt++;
    end
    checkOutput("s8DoneSeen", s8Done, 1);
    @(posedge clk); #1;
  endtask

  logic [15:0] sweepExp [3][4] = '{
    '{16'd25, 16'hFFF9, 16'd0, 16'hFFEF},
    '{16'd13, 16'd5,    16'd0, 16'hFFFB},
    '{16'd13, 16'd5,    16'd0, 16'hFFFB}
  };

  // Directed test sequence.
  initial begin
    logic [9:0] readyVec, doneVec;
    logic       doneAcc;
    exp_t       e;

    rst_n = 1'b0; start = 1'b0; opLoad = 1'b0; rd = '0; rn = '0; rm = '0;
    shiftOp = '0; aluOp = '0; selA = 1'b0; selB = 1'b0; imm = '0; wbEn = 1'b0; din = '0;
    s8Start = 1'b0; s8OpLoad = 1'b0; s8Rd = '0; s8Rn = '0; s8Rm = '0; s8Din = '0;
    s8Zero2 = '0; s8Zero1 = 1'b0; s8Imm = '0; s8WbEn = 1'b1;
    for (int i = 0; i < 8; i++) mdlReg[i] = 16'd0;
    mdlState = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstReady", ready, 1);
    checkOutput("rstDone", done, 0);
    checkOutput("rstC", dout, 0);
    checkOutput("rstFlags", {nOut, zOut, vOut}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Load then ADD.
    $display("[TB] load/add");
    loadReg(3'd0, 16'd9);
    loadReg(3'd1, 16'd8);
    applyStimulus(1'b0, 3'd2, 3'd0, 3'd1, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b1, 16'd0);
    checkOutput("add17", dout, 16'd17);
    readRegExpect(3'd2, 16'd17);

    // Operand selection: A forced to zero, then B from the immediate.
    applyStimulus(1'b0, 3'd6, 3'd0, 3'd1, 2'd0, 2'd0, 1'b1, 1'b0, 5'd0, 1'b0, 16'd0);
    checkOutput("selA", dout, 16'd8);
    applyStimulus(1'b0, 3'd6, 3'd0, 3'd1, 2'd0, 2'd0, 1'b0, 1'b1, 5'b11111, 1'b0, 16'd0);
    checkOutput("selBimm", dout, 16'd8);

    // Shift x ALU sweep with A=9, B=8.
    $display("[TB] shift/alu sweep");
    for (int s = 1; s <= 3; s++) begin
      for (int a = 0; a < 4; a++) begin
        applyStimulus(1'b0, 3'd6, 3'd0, 3'd1, 2'(s), 2'(a), 1'b0, 1'b0, 5'd0, 1'b0, 16'd0);
        checkOutput($sformatf("sweep s%0d a%0d", s, a), dout, sweepExp[s-1][a]);
      end
    end

    // Flags: signed overflow, zero on compare-only, V cleared by AND.
    $display("[TB] flags");
    loadReg(3'd3, 16'h7FFF);
    loadReg(3'd4, 16'd1);
    applyStimulus(1'b0, 3'd5, 3'd3, 3'd4, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b1, 16'd0);
    checkOutput("ovfC", dout, 16'h8000);
    checkOutput("ovfVN", {vOut, nOut}, 2'b11);
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 2'd0, 2'd1, 1'b0, 1'b0, 5'd0, 1'b0, 16'd0);
    checkOutput("subZ", zOut, 1);
    readRegExpect(3'd0, 16'd9);
    loadReg(3'd6, 16'hFFFF);
    applyStimulus(1'b0, 3'd1, 3'd5, 3'd6, 2'd0, 2'd2, 1'b0, 1'b0, 5'd0, 1'b0, 16'd0);
    checkOutput("andVN", {vOut, nOut}, 2'b01);

    // Handshake with start held high; a load request appears while busy and
    // must be ignored, the ALU fields are back in place before re-acceptance.
    $display("[TB] handshake");
    opLoad = 1'b0; rd = 3'd4; rn = 3'd0; rm = 3'd1; shiftOp = 2'd0; aluOp = 2'd0;
    selA = 1'b0; selB = 1'b0; imm = 5'd0; wbEn = 1'b1; din = 16'd0;
    start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      readyVec[k] = ready;
      doneVec[k]  = done;
      if (k == 1) begin opLoad = 1'b1; rd = 3'd7; din = 16'h1234; end
      if (k == 3) begin opLoad = 1'b0; rd = 3'd4; din = 16'd0; end
    end
    start = 1'b0;
    e = modelAlu(mdlReg[0], mdlReg[1], 2'd0, 2'd0, 1'b0, 1'b0, 5'd0);
    mdlState  = e;
    mdlReg[4] = e.data;
    checkOutput("hsReady", readyVec, 10'h210);
    checkOutput("hsDone", doneVec, 10'h108);
    checkOutput("hsC", dout, 16'd17);
    readRegExpect(3'd7, 16'd0);
    readRegExpect(3'd4, 16'd17);

    // Reset while the instruction is in EXEC.
    $display("[TB] reset mid-exec");
    loadReg(3'd3, 16'h00AA);
    readRegExpect(3'd3, 16'h00AA);
    opLoad = 1'b0; rd = 3'd3; rn = 3'd0; rm = 3'd1; shiftOp = 2'd0; aluOp = 2'd0;
    selA = 1'b0; selB = 1'b0; wbEn = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("abortReady", ready, 1);
    checkOutput("abortDone", done, 0);
    checkOutput("abortC", dout, 0);
    checkOutput("abortFlags", {nOut, zOut, vOut}, 0);
    rst_n = 1'b1;
    doneAcc = 1'b0;
    repeat (6) begin @(posedge clk); #1; doneAcc |= done; end
    checkOutput("abortNoDone", doneAcc, 0);
    for (int i = 0; i < 8; i++) mdlReg[i] = 16'd0;
    mdlState = '0;
    readRegExpect(3'd3, 16'd0);
    readRegExpect(3'd0, 16'd0);
    readRegExpect(3'd1, 16'd0);

    // Narrow instance: 0x7F + 1 overflows in 8 bits.
    $display("[TB] 8-bit instance");
    applyStimulus8(1'b1, 2'd0, 2'd0, 2'd0, 8'h7F);
    applyStimulus8(1'b1, 2'd1, 2'd0, 2'd0, 8'h01);
    applyStimulus8(1'b0, 2'd2, 2'd0, 2'd1, 8'h00);
    checkOutput("s8C", s8Out, 8'h80);
    checkOutput("s8V", s8V, 1);
    checkOutput("s8N", s8N, 1);
    checkOutput("s8Z", s8Z, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
